fetch_redirect: RTL and testbench

- Consumes execute-stage branch/jump resolution (take_branch, immediate, operand values) and owns the fetch program counter.
- Sequences PC increment, branch/jump redirect, and the flush of the two younger pipeline latches (F/D, D/X).
- Holds a redirect pending while the hazard unit stalls the front end.
- Sits between the execute stage and the instruction-memory address port.

---
 rtl/fetch_redirect_if.sv | 39 +++
 rtl/fetch_redirect.sv | 127 ++++++++++++
 tb/tb_fetch_redirect.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_if.sv
// Bundle of hazard-unit, execute-stage and fetch-address signals around fetch_redirect.
// master = EX/hazard side driving resolutions, slave = the fetch PC block (FETCH_REDIRECT_STATS_EN adds redirect_count).
interface fetch_redirect_if #(
    parameter int PC_WIDTH = 32
);
    logic                stall;
    logic                ex_valid;
    logic [4:0]          ex_opcode;
    logic                ex_take_branch;
    logic [PC_WIDTH-1:0] ex_pc;
    logic [16:0]         ex_immediate;
    logic [26:0]         ex_target;
    logic [31:0]         ex_rd_value;
    logic [PC_WIDTH-1:0] pc;
    logic                flush_fd;
    logic                flush_dx;
    logic                redirect_pending;
`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0]         redirect_count;
`endif

    modport master (
        output stall, ex_valid, ex_opcode, ex_take_branch, ex_pc,
               ex_immediate, ex_target, ex_rd_value,
        input  pc, flush_fd, flush_dx, redirect_pending
`ifdef FETCH_REDIRECT_STATS_EN
             , redirect_count
`endif
    );

    modport slave (
        input  stall, ex_valid, ex_opcode, ex_take_branch, ex_pc,
               ex_immediate, ex_target, ex_rd_value,
        output pc, flush_fd, flush_dx, redirect_pending
`ifdef FETCH_REDIRECT_STATS_EN
             , redirect_count
`endif
    );
endinterface

// File: rtl/fetch_redirect.sv
// Purpose: owns the fetch PC; applies EX branch/jump redirects and flushes F/D and D/X.
// Latency: redirect on pc one cycle after apply; stall freezes pc and parks a redirect in PENDING.
// Optional FETCH_REDIRECT_STATS_EN: adds a 32-bit count of applied redirects.
module fetch_redirect #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic          clock,
    input logic          reset_n,
    fetch_redirect_if.slave bus
);
    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] pend_q;
    logic [PC_WIDTH-1:0] pend_next;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] imm_ext;
    logic                hit_jr;
    logic                hit_jump;
    logic                hit_branch;
    logic                redirect;
    logic                apply;

    // Resolution decode; opcodes are disjoint but the priority chain keeps jr > jump > branch explicit.
    always_comb begin
        hit_jr     = bus.ex_valid && (bus.ex_opcode == OP_JR);
        hit_jump   = bus.ex_valid && ((bus.ex_opcode == OP_J) || (bus.ex_opcode == OP_JAL));
        hit_branch = bus.ex_valid && bus.ex_take_branch &&
                     ((bus.ex_opcode == OP_BNE) || (bus.ex_opcode == OP_BLT) ||
                      (bus.ex_opcode == OP_BEX));
        redirect   = hit_jr || hit_jump || hit_branch;
        imm_ext    = PC_WIDTH'($signed(bus.ex_immediate));
        target     = '0;
        if (hit_jr) begin
            target = bus.ex_rd_value[PC_WIDTH-1:0];
        end else if (hit_jump) begin
            target = PC_WIDTH'(bus.ex_target);
        end else if (hit_branch) begin
            if (bus.ex_opcode == OP_BEX) begin
                target = PC_WIDTH'(bus.ex_target);
            end else begin
                target = bus.ex_pc + PC_WIDTH'(1) + imm_ext;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RUN;
            pc_q   <= RESET_PC;
            pend_q <= '0;
        end else begin
            state  <= state_next;
            pc_q   <= pc_next;
            pend_q <= pend_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        pend_next  = pend_q;
        apply      = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    if (bus.stall) begin
                        pend_next  = target;
                        state_next = PENDING;
                    end else begin
                        pc_next = target;
                        apply   = 1'b1;
                    end
                end else if (!bus.stall) begin
                    pc_next = pc_q + PC_WIDTH'(1);
                end
            end
            PENDING: begin
                // EX contents are ignored here: the oldest captured redirect wins.
                if (!bus.stall) begin
                    pc_next    = pend_q;
                    apply      = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign bus.pc               = pc_q;
    assign bus.flush_fd         = apply;
    assign bus.flush_dx         = apply;
    assign bus.redirect_pending = (state == PENDING);

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (apply) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.redirect_count = count_q;
`endif

    a_no_flush_in_stall: assert property (@(posedge clock) disable iff (!reset_n)
        apply |-> !bus.stall);
    a_pending_freezes_pc: assert property (@(posedge clock) disable iff (!reset_n)
        (state == PENDING && bus.stall) |=> (pc_q == $past(pc_q)));
endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: reference model of the fetch PC plus literal spot checks.
module tb_fetch_redirect;
    localparam logic [4:0] J   = 5'b00001;
    localparam logic [4:0] BNE = 5'b00010;
    localparam logic [4:0] JAL = 5'b00011;
    localparam logic [4:0] JR  = 5'b00100;
    localparam logic [4:0] BLT = 5'b00110;
    localparam logic [4:0] BEX = 5'b10110;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    fetch_redirect_if #(.PC_WIDTH(32)) bus ();

    fetch_redirect #(.PC_WIDTH(32), .RESET_PC(32'd0)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // What EX is asking for this cycle: {redirect, target}.
    function automatic logic [32:0] predict(input logic v, input logic [4:0] op, input logic tk,
                                            input logic [31:0] epc, input logic [16:0] imm,
                                            input logic [26:0] tg, input logic [31:0] rd);
        logic [31:0] off;
        off = {{15{imm[16]}}, imm};
        if (!v) return 33'd0;
        case (op)
            JR:       return {1'b1, rd};
            J, JAL:   return {1'b1, 5'd0, tg};
            BNE, BLT: return tk ? {1'b1, epc + 32'd1 + off} : 33'd0;
            BEX:      return tk ? {1'b1, 5'd0, tg} : 33'd0;
            default:  return 33'd0;
        endcase
    endfunction

    logic [32:0] pr_now;
    assign pr_now = predict(bus.ex_valid, bus.ex_opcode, bus.ex_take_branch, bus.ex_pc,
                            bus.ex_immediate, bus.ex_target, bus.ex_rd_value);

    logic [31:0] mpc    = '0;
    logic        mpend  = 1'b0;
    logic [31:0] mtgt   = '0;
    logic [31:0] mcount = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mpc    <= '0;
            mpend  <= 1'b0;
            mtgt   <= '0;
            mcount <= '0;
        end else if (mpend) begin
            if (!bus.stall) begin
                mpc    <= mtgt;
                mpend  <= 1'b0;
                mcount <= mcount + 32'd1;
            end
        end else if (pr_now[32]) begin
            if (bus.stall) begin
                mpend <= 1'b1;
                mtgt  <= pr_now[31:0];
            end else begin
                mpc    <= pr_now[31:0];
                mcount <= mcount + 32'd1;
            end
        end else if (!bus.stall) begin
            mpc <= mpc + 32'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic tk, input logic [31:0] epc,
                         input logic [16:0] imm, input logic [26:0] tg, input logic [31:0] rd);
        bus.ex_valid       = v;
        bus.ex_opcode      = op;
        bus.ex_take_branch = tk;
        bus.ex_pc          = epc;
        bus.ex_immediate   = imm;
        bus.ex_target      = tg;
        bus.ex_rd_value    = rd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 32'd0, 17'd0, 27'd0, 32'd0);
    endtask

    task automatic compare_loop();
        logic exp_flush;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                exp_flush = !bus.stall && (mpend || pr_now[32]);
                check("model_pc", bus.pc, mpc);
                check("model_flush_fd", 32'(bus.flush_fd), 32'(exp_flush));
                check("model_flush_dx", 32'(bus.flush_dx), 32'(exp_flush));
                check("model_pending", 32'(bus.redirect_pending), 32'(mpend));
`ifdef FETCH_REDIRECT_STATS_EN
                check("model_count", bus.redirect_count, mcount);
`endif
            end
        end
    endtask

    initial begin
        logic [31:0] p0;
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        bus.stall = 1'b0;
        idle();
        fork
            compare_loop();
        join_none

        repeat (2) @(posedge clock);
        #1;
        check("reset_pc", bus.pc, 32'd0);
        check("reset_flush", 32'(bus.flush_fd | bus.flush_dx), 32'd0);
        check("reset_pending", 32'(bus.redirect_pending), 32'd0);
        reset_n = 1'b1;

        // Free-running increment after reset.
        for (int i = 0; i < 5; i++) begin
            check("inc_pc", bus.pc, 32'(i));
            check("inc_flush", 32'(bus.flush_fd), 32'd0);
            cyc();
        end

        // bne taken: 10 + 1 - 3 = 8.
        drive(1'b1, BNE, 1'b1, 32'd10, 17'h1FFFD, 27'd0, 32'd0);
        #1;
        check("bne_flush_fd", 32'(bus.flush_fd), 32'd1);
        check("bne_flush_dx", 32'(bus.flush_dx), 32'd1);
        cyc();
        idle();
        #1;
        check("bne_pc", bus.pc, 32'd8);
        check("bne_flush_once", 32'(bus.flush_fd), 32'd0);
        cyc();
        check("bne_pc_next", bus.pc, 32'd9);

        // jal captured under a 3-cycle stall; a later jr must not displace it.
        bus.stall = 1'b1;
        drive(1'b1, JAL, 1'b0, 32'd0, 17'd0, 27'h100, 32'd0);
        #1;
        check("jal_stall_noflush", 32'(bus.flush_fd), 32'd0);
        p0 = bus.pc;
        cyc();
        drive(1'b1, JR, 1'b0, 32'd0, 17'd0, 27'd0, 32'h999);
        #1;
        check("jal_pending1", 32'(bus.redirect_pending), 32'd1);
        check("jal_frozen1", bus.pc, p0);
        cyc();
        idle();
        check("jal_pending2", 32'(bus.redirect_pending), 32'd1);
        cyc();
        check("jal_frozen3", bus.pc, p0);
        bus.stall = 1'b0;
        #1;
        check("jal_release_flush", 32'(bus.flush_dx), 32'd1);
        cyc();
        check("jal_pc", bus.pc, 32'h100);
        check("jal_pending_clr", 32'(bus.redirect_pending), 32'd0);
        check("jal_flush_once", 32'(bus.flush_fd), 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
        check("count_after_jal", bus.redirect_count, 32'd2);
`endif

        // jr with take_branch also high.
        drive(1'b1, JR, 1'b1, 32'd0, 17'd0, 27'd0, 32'h40);
        #1;
        check("jr_flush", 32'(bus.flush_fd), 32'd1);
        cyc();
        idle();
        check("jr_pc", bus.pc, 32'h40);

        // Non-redirecting branches.
        drive(1'b0, BNE, 1'b1, 32'h40, 17'd50, 27'd0, 32'd0);
        #1;
        check("bubble_noflush", 32'(bus.flush_fd), 32'd0);
        cyc();
        check("bubble_pc", bus.pc, 32'h41);
        drive(1'b1, BLT, 1'b0, 32'h41, 17'd50, 27'd0, 32'd0);
        cyc();
        check("nottaken_pc", bus.pc, 32'h42);
        drive(1'b1, 5'b11111, 1'b1, 32'h42, 17'd50, 27'd0, 32'd0);
        cyc();
        check("badop_pc", bus.pc, 32'h43);

        // Wrap cases and remaining target forms.
        drive(1'b1, JR, 1'b0, 32'd0, 17'd0, 27'd0, 32'hFFFF_FFFF);
        cyc();
        idle();
        check("jr_max_pc", bus.pc, 32'hFFFF_FFFF);
        cyc();
        check("wrap_pc", bus.pc, 32'd0);
        drive(1'b1, BLT, 1'b1, 32'hFFFF_FFFE, 17'd5, 27'd0, 32'd0);
        cyc();
        check("blt_wrap_pc", bus.pc, 32'd4);
        drive(1'b1, BEX, 1'b1, 32'd4, 17'd0, 27'h7FF_FFFF, 32'd0);
        cyc();
        check("bex_pc", bus.pc, 32'h07FF_FFFF);
        drive(1'b1, BNE, 1'b1, 32'd100, 17'h10000, 27'd0, 32'd0);
        cyc();
        idle();
        check("bne_negmax_pc", bus.pc, 32'hFFFF_0065);

        // Reset while a redirect is pending discards it.
        bus.stall = 1'b1;
        drive(1'b1, J, 1'b0, 32'd0, 17'd0, 27'h55, 32'd0);
        cyc();
        idle();
        check("rst_pend_set", 32'(bus.redirect_pending), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_pend_pc", bus.pc, 32'd0);
        check("rst_pend_clr", 32'(bus.redirect_pending), 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
        check("rst_count", bus.redirect_count, 32'd0);
`endif
        cyc();
        reset_n   = 1'b1;
        bus.stall = 1'b0;
        #1;
        check("rst_release_noflush", 32'(bus.flush_fd), 32'd0);
        cyc();
        check("rst_release_pc", bus.pc, 32'd1);
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
